// File: rtl/mem_arb_pkg.sv
// Shared types, constants and helpers for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_BURST = 2'b01,
        D_ACCESS = 2'b10
    } state_e;

    // Which requester owns the access that is in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // The memory is only ever driven in single-word mode.
    localparam logic [1:0]  ACCESS_SINGLE = 2'b00;

    // Byte distance between consecutive word beats.
    localparam logic [31:0] WORD_STEP     = 32'd4;

    // Mask that forces a byte address onto a word boundary.
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    // Number of single-word beats for a fetch burst size code.
    function automatic logic [4:0] burst_len(input logic [1:0] size);
        logic [4:0] len;
        case (size)
            2'b00:   len = 5'd1;
            2'b01:   len = 5'd4;
            2'b10:   len = 5'd8;
            2'b11:   len = 5'd16;
            default: len = 5'd1;
        endcase
        return len;
    endfunction

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_burst_seq.sv
// Beat sequencer: walks the word address of an access and tracks how many
// beats have been accepted by the memory so the arbiter knows when to stop.
module mem_burst_seq
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,       // load a new access (arbiter grant)
    input  logic [31:0] base_addr_i,   // word-aligned first beat address
    input  logic [4:0]  beat_total_i,  // beats in the new access (1..16)
    input  logic        enable_i,      // a beat is currently offered to memory
    input  logic        busy_i,        // memory stall
    output logic [31:0] addr_o,        // address of the beat being offered
    output logic        beat_acc_o,    // beat accepted on the coming edge
    output logic        last_beat_o    // the accepted beat is the final one
);

    logic [31:0] addr_q,  addr_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [4:0]  total_q, total_d;
    logic        beat_acc_s;
    logic        last_beat_s;

    // Acceptance qualifiers: a beat goes through only when offered and not stalled.
    always_comb begin
        beat_acc_s  = enable_i & ~busy_i;
        if (beat_acc_s) begin
            last_beat_s = (cnt_q == (total_q - 5'd1));
        end else begin
            last_beat_s = 1'b0;
        end
    end

    // Next address / beat count: load on start, advance on each accepted beat.
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        if (start_i) begin
            addr_d  = base_addr_i;
            cnt_d   = 5'd0;
            total_d = beat_total_i;
        end else if (beat_acc_s) begin
            addr_d  = addr_q + WORD_STEP;   // wraps naturally mod 2^32
            cnt_d   = cnt_q + 5'd1;
        end else begin
            addr_d  = addr_q;
            cnt_d   = cnt_q;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            cnt_q   <= 5'd0;
            total_q <= 5'd0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    assign addr_o      = addr_q;
    assign beat_acc_o  = beat_acc_s;
    assign last_beat_o = last_beat_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-word memory between the fetch port (bursts, read-only)
// and the data port (single load/store). Fetch bursts are split into word
// beats; read data is routed back to the owner one cycle after acceptance.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic [1:0]  if_size_i,
    output logic        if_grant_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_done_o,
    // data port
    input  logic        d_req_i,
    input  logic        d_rw_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_grant_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_done_o,
    // memory side
    output logic        mem_enable_o,
    output logic        mem_read_write_o,
    output logic [31:0] mem_address_o,
    output logic [1:0]  mem_access_size_o,
    output logic [31:0] mem_data_in_o,
    input  logic [31:0] mem_data_out_i,
    input  logic        mem_busy_i
);

    localparam int unsigned     SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    state_e         state_q,      state_d;
    owner_e         owner_q,      owner_d;
    logic [SW-1:0]  starve_q,     starve_d;

    logic           mem_enable_q, mem_enable_d;
    logic           mem_rw_q,     mem_rw_d;
    logic [31:0]    mem_wdata_q,  mem_wdata_d;
    logic           if_grant_q,   if_grant_d;
    logic           d_grant_q,    d_grant_d;
    logic           if_rv_q,      if_rv_d;
    logic           if_done_q,    if_done_d;
    logic           d_rv_q,       d_rv_d;
    logic           d_done_q,     d_done_d;

    logic           grant_if_s;
    logic           grant_d_s;
    logic           start_s;
    logic [31:0]    base_s;
    logic [4:0]     total_s;
    logic [31:0]    seq_addr_s;
    logic           beat_acc_s;
    logic           last_beat_s;

    // Beat address and acceptance tracking for the access in flight.
    mem_burst_seq u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_s),
        .base_addr_i  (base_s),
        .beat_total_i (total_s),
        .enable_i     (mem_enable_q),
        .busy_i       (mem_busy_i),
        .addr_o       (seq_addr_s),
        .beat_acc_o   (beat_acc_s),
        .last_beat_o  (last_beat_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration: data wins ties unless fetch has been starved.
    always_comb begin
        state_d    = state_q;
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req_i && (!if_req_i || (starve_q != STARVE_MAX))) begin
                    grant_d_s = 1'b1;
                    state_d   = D_ACCESS;
                end else if (if_req_i) begin
                    grant_if_s = 1'b1;
                    state_d    = IF_BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_BURST, D_ACCESS: begin
                if (last_beat_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer load values taken from whichever requester is granted.
    always_comb begin
        start_s = grant_if_s | grant_d_s;
        if (grant_if_s) begin
            base_s  = word_align(if_addr_i);
            total_s = burst_len(if_size_i);
        end else begin
            base_s  = word_align(d_addr_i);
            total_s = 5'd1;
        end
    end

    // Output next-values: grant pulses, memory controls, starve count, return flags.
    always_comb begin
        owner_d      = owner_q;
        starve_d     = starve_q;
        mem_enable_d = mem_enable_q;
        mem_rw_d     = mem_rw_q;
        mem_wdata_d  = mem_wdata_q;
        if_grant_d   = grant_if_s;
        d_grant_d    = grant_d_s;

        if (grant_if_s) begin
            owner_d      = OWN_IF;
            starve_d     = '0;
            mem_enable_d = 1'b1;
            mem_rw_d     = 1'b1;
            mem_wdata_d  = 32'd0;
        end else if (grant_d_s) begin
            owner_d      = OWN_D;
            mem_enable_d = 1'b1;
            mem_rw_d     = d_rw_i;
            if (d_rw_i) begin
                mem_wdata_d = 32'd0;
            end else begin
                mem_wdata_d = d_wdata_i;
            end
            if (if_req_i && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end else if (last_beat_s) begin
            mem_enable_d = 1'b0;
        end else begin
            mem_enable_d = mem_enable_q;
        end

        // Return flags are set by an accepted beat and routed by the latched owner,
        // so the final return may land on the idle bubble after ownership ends.
        if_rv_d   = beat_acc_s  & mem_rw_q & (owner_q == OWN_IF);
        if_done_d = last_beat_s & (owner_q == OWN_IF);
        d_rv_d    = beat_acc_s  & mem_rw_q & (owner_q == OWN_D);
        d_done_d  = last_beat_s & (owner_q == OWN_D);
    end

    // Registered outputs and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IF;
            starve_q     <= '0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
            if_grant_q   <= 1'b0;
            d_grant_q    <= 1'b0;
            if_rv_q      <= 1'b0;
            if_done_q    <= 1'b0;
            d_rv_q       <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            mem_enable_q <= mem_enable_d;
            mem_rw_q     <= mem_rw_d;
            mem_wdata_q  <= mem_wdata_d;
            if_grant_q   <= if_grant_d;
            d_grant_q    <= d_grant_d;
            if_rv_q      <= if_rv_d;
            if_done_q    <= if_done_d;
            d_rv_q       <= d_rv_d;
            d_done_q     <= d_done_d;
        end
    end

    // Read data is only passed through while its valid flag is up.
    always_comb begin
        if (if_rv_q) begin
            if_rdata_o = mem_data_out_i;
        end else begin
            if_rdata_o = 32'd0;
        end
        if (d_rv_q) begin
            d_rdata_o = mem_data_out_i;
        end else begin
            d_rdata_o = 32'd0;
        end
    end

    assign if_grant_o        = if_grant_q;
    assign if_rvalid_o       = if_rv_q;
    assign if_done_o         = if_done_q;
    assign d_grant_o         = d_grant_q;
    assign d_rvalid_o        = d_rv_q;
    assign d_done_o          = d_done_q;
    assign mem_enable_o      = mem_enable_q;
    assign mem_read_write_o  = mem_rw_q;
    assign mem_address_o     = seq_addr_s;
    assign mem_access_size_o = ACCESS_SINGLE;
    assign mem_data_in_o     = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and
// scoreboards of expected read returns for both ports.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req, d_req, d_rw, mem_busy;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  if_size;
    logic        if_grant, if_rvalid, if_done;
    logic [31:0] if_rdata;
    logic        d_grant, d_rvalid, d_done;
    logic [31:0] d_rdata;
    logic        mem_enable, mem_read_write;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;

    typedef struct { logic [31:0] data; logic last; } if_exp_t;
    typedef struct { logic rd; logic [31:0] data; } d_exp_t;

    if_exp_t if_q[$];
    d_exp_t  d_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_arr [256];
    bit   [255:0] wr_valid;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_req_i          (if_req),
        .if_addr_i         (if_addr),
        .if_size_i         (if_size),
        .if_grant_o        (if_grant),
        .if_rvalid_o       (if_rvalid),
        .if_rdata_o        (if_rdata),
        .if_done_o         (if_done),
        .d_req_i           (d_req),
        .d_rw_i            (d_rw),
        .d_addr_i          (d_addr),
        .d_wdata_i         (d_wdata),
        .d_grant_o         (d_grant),
        .d_rvalid_o        (d_rvalid),
        .d_rdata_o         (d_rdata),
        .d_done_o          (d_done),
        .mem_enable_o      (mem_enable),
        .mem_read_write_o  (mem_read_write),
        .mem_address_o     (mem_address),
        .mem_access_size_o (mem_access_size),
        .mem_data_in_o     (mem_data_in),
        .mem_data_out_i    (mem_data_out),
        .mem_busy_i        (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default contents of never-written memory words.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h000000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Behavioural single-word memory: read data appears the cycle after acceptance.
    always @(posedge clk) begin
        if (mem_enable && !mem_busy) begin
            if (mem_read_write) begin
                mem_data_out <= wr_valid[mem_address[9:2]] ? mem_arr[mem_address[9:2]]
                                                           : pat(mem_address);
            end else begin
                mem_arr[mem_address[9:2]]  <= mem_data_in;
                wr_valid[mem_address[9:2]] <= 1'b1;
            end
        end
    end

    // Scoreboard monitor: every return is matched against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid) begin
                chk("if_q_nonempty", 64'(if_q.size() != 0), 64'd1);
                if (if_q.size() != 0) begin
                    if_exp_t e;
                    e = if_q.pop_front();
                    chk("if_rdata", 64'(if_rdata), 64'(e.data));
                    chk("if_done", 64'(if_done), 64'(e.last));
                end
            end else begin
                chk("if_rdata_idle", 64'(if_rdata), 64'd0);
            end
            if (if_done) chk("if_done_with_rvalid", 64'(if_rvalid), 64'd1);
            if (d_rvalid) chk("d_done_with_rvalid", 64'(d_done), 64'd1);
            else          chk("d_rdata_idle", 64'(d_rdata), 64'd0);
            if (d_done) begin
                chk("d_q_nonempty", 64'(d_q.size() != 0), 64'd1);
                if (d_q.size() != 0) begin
                    d_exp_t e;
                    e = d_q.pop_front();
                    chk("d_rvalid", 64'(d_rvalid), 64'(e.rd));
                    if (e.rd) chk("d_rdata", 64'(d_rdata), 64'(e.data));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({if_grant, if_rvalid, if_done, d_grant, d_rvalid, d_done,
                                mem_enable, mem_read_write, mem_access_size}), 64'd0);
        chk({tag, "_data"}, 64'({|if_rdata, |d_rdata, |mem_address, |mem_data_in}), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        gseq [6];
        int          ng;

        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; mem_busy = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; if_size = 2'b00;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fetch burst of 4 at 0x100.
        if_req = 1'b1; if_addr = 32'h100; if_size = 2'b01;
        for (int i = 0; i < 4; i++) if_q.push_back('{pat(32'h100 + 32'(4 * i)), (i == 3)});
        tick();
        chk("f_grant", 64'(if_grant), 64'd1);
        chk("f_dgrant", 64'(d_grant), 64'd0);
        chk("f_en0", 64'(mem_enable), 64'd1);
        chk("f_rw", 64'(mem_read_write), 64'd1);
        chk("f_addr0", 64'(mem_address), 64'h100);
        if_req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("f_addr", 64'(mem_address), 64'(32'h100 + 32'(4 * i)));
            chk("f_en", 64'(mem_enable), 64'd1);
            chk("f_grant_pulse", 64'(if_grant), 64'd0);
        end
        tick();
        chk("f_en_off", 64'(mem_enable), 64'd0);
        chk("f_done", 64'(if_done), 64'd1);
        repeat (2) tick();
        chk("f_drained", 64'(if_q.size()), 64'd0);

        // Data write with three busy cycles, then read back.
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h40; d_wdata = 32'd234; mem_busy = 1'b1;
        d_q.push_back('{1'b0, 32'd0});
        tick();
        chk("w_grant", 64'(d_grant), 64'd1);
        chk("w_rw", 64'(mem_read_write), 64'd0);
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("w_addr_hold", 64'(mem_address), 64'h40);
            chk("w_data_hold", 64'(mem_data_in), 64'd234);
            chk("w_en_hold", 64'(mem_enable), 64'd1);
            chk("w_no_done", 64'(d_done), 64'd0);
        end
        mem_busy = 1'b0;
        tick();
        chk("w_done", 64'(d_done), 64'd1);
        chk("w_no_rvalid", 64'(d_rvalid), 64'd0);
        chk("w_en_off", 64'(mem_enable), 64'd0);
        tick();
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h40;
        d_q.push_back('{1'b1, 32'd234});
        tick();
        chk("r_grant", 64'(d_grant), 64'd1);
        chk("r_wdata_zero", 64'(mem_data_in), 64'd0);
        d_req = 1'b0;
        tick();
        chk("r_rvalid", 64'(d_rvalid), 64'd1);
        chk("r_rdata", 64'(d_rdata), 64'd234);
        tick();
        chk("d_drained", 64'(d_q.size()), 64'd0);

        // Wrap and alignment of the fetch address.
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE; if_size = 2'b01;
        for (int i = 0; i < 4; i++) begin
            a = 32'hFFFF_FFFC + 32'(4 * i);
            if_q.push_back('{pat(a), (i == 3)});
        end
        tick();
        chk("wrap_grant", 64'(if_grant), 64'd1);
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            a = 32'hFFFF_FFFC + 32'(4 * i);
            chk("wrap_addr", 64'(mem_address), 64'(a));
        end
        repeat (3) tick();
        chk("wrap_drained", 64'(if_q.size()), 64'd0);

        // Both requesting continuously: D,D,D,D,IF,D.
        if_req = 1'b1; if_addr = 32'h180; if_size = 2'b00;
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h80;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick();
            chk("one_grant", 64'(if_grant & d_grant), 64'd0);
            if (d_grant) begin
                gseq[ng] = 1'b1; ng++;
                d_q.push_back('{1'b1, pat(32'h80)});
            end else if (if_grant) begin
                gseq[ng] = 1'b0; ng++;
                if_q.push_back('{pat(32'h180), 1'b1});
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("arb_grant_count", 64'(ng), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("arb_order", 64'(gseq[i]), (i == 4) ? 64'd0 : 64'd1);
        end
        repeat (3) tick();
        chk("arb_if_drained", 64'(if_q.size()), 64'd0);
        chk("arb_d_drained", 64'(d_q.size()), 64'd0);

        // Last data read overlaps the idle bubble while fetch waits.
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h40;
        d_q.push_back('{1'b1, 32'd234});
        tick();
        chk("ov_dgrant", 64'(d_grant), 64'd1);
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h200; if_size = 2'b00;
        tick();
        chk("ov_drvalid", 64'(d_rvalid), 64'd1);
        chk("ov_ddone", 64'(d_done), 64'd1);
        chk("ov_no_ifrv", 64'(if_rvalid), 64'd0);
        chk("ov_no_ifgrant", 64'(if_grant), 64'd0);
        tick();
        chk("ov_ifgrant", 64'(if_grant), 64'd1);
        chk("ov_addr", 64'(mem_address), 64'h200);
        if_q.push_back('{pat(32'h200), 1'b1});
        if_req = 1'b0;
        repeat (3) tick();
        chk("ov_drained", 64'(if_q.size() + d_q.size()), 64'd0);

        // Reset in the middle of a 16-beat burst.
        if_req = 1'b1; if_addr = 32'h300; if_size = 2'b11;
        for (int i = 0; i < 16; i++) if_q.push_back('{pat(32'h300 + 32'(4 * i)), (i == 15)});
        tick();
        chk("rb_grant", 64'(if_grant), 64'd1);
        if_req = 1'b0;
        repeat (5) tick();
        chk("rb_beat5_addr", 64'(mem_address), 64'h314);
        #2;
        rst_n = 1'b0;
        if_q.delete();
        #1;
        check_all_zero("mid_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("rb_idle_en", 64'(mem_enable), 64'd0);
        chk("rb_no_returns", 64'(if_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
